// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions: the active-low segment patterns driven
// by the display controller (dp bit off) and the digit slot indices used by
// the ctrl scan lines.
package ssd_pkg;

    // Patterns are {a,b,c,d,e,f,g,dp}, all active-low, dp always off.
    localparam logic [7:0] SSD_0 = 8'b0000001_1;
    localparam logic [7:0] SSD_1 = 8'b1001111_1;
    localparam logic [7:0] SSD_2 = 8'b0010010_1;
    localparam logic [7:0] SSD_3 = 8'b0000110_1;
    localparam logic [7:0] SSD_4 = 8'b1001100_1;
    localparam logic [7:0] SSD_5 = 8'b0100100_1;
    localparam logic [7:0] SSD_6 = 8'b0100000_1;
    localparam logic [7:0] SSD_7 = 8'b0001111_1;
    localparam logic [7:0] SSD_8 = 8'b0000000_1;
    localparam logic [7:0] SSD_9 = 8'b0000100_1;
    localparam logic [7:0] SSD_F = 8'b0111000_1;

    // Digit slot index == ctrl bit position that enables that digit.
    localparam int DIG_MIN_T = 3;
    localparam int DIG_MIN_O = 2;
    localparam int DIG_SEC_T = 1;
    localparam int DIG_SEC_O = 0;

    // One shadow slot: decoded nibble plus its undecodable flag.
    typedef struct packed {
        logic [3:0] nibble;
        logic       bad;
    } digit_t;

    // Number of asserted (low) enables on the active-low ctrl bus.
    function automatic logic [2:0] zero_count(input logic [3:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, ~v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/ssd_pattern_decoder.sv
// Combinational seven-segment pattern to BCD nibble decoder. Unknown
// patterns decode to F and raise bad; the explicit F pattern is legal.
module ssd_pattern_decoder
    import ssd_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       bad
);

    // Map each legal segment pattern to its digit value.
    always_comb begin
        nibble = 4'hF;
        bad    = 1'b0;
        case (seg)
            SSD_0[7:1]: nibble = 4'h0;
            SSD_1[7:1]: nibble = 4'h1;
            SSD_2[7:1]: nibble = 4'h2;
            SSD_3[7:1]: nibble = 4'h3;
            SSD_4[7:1]: nibble = 4'h4;
            SSD_5[7:1]: nibble = 4'h5;
            SSD_6[7:1]: nibble = 4'h6;
            SSD_7[7:1]: nibble = 4'h7;
            SSD_8[7:1]: nibble = 4'h8;
            SSD_9[7:1]: nibble = 4'h9;
            SSD_F[7:1]: nibble = 4'hF;
            default: begin
                nibble = 4'hF;
                bad    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seven_segment_display_decoder.sv
// Display monitor: samples the scanned display/ctrl pins, decodes each digit,
// collects all four slots into a frame and publishes minutes/seconds, with
// frame/error pulses plus stability and scan-loss status.
module seven_segment_display_decoder
    import ssd_pkg::*;
#(
    parameter int STABLE_FRAMES = 4,
    parameter int TIMEOUT_CYC   = 1024
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] display,
    input  logic [3:0] ctrl,
    output logic [7:0] min_BCD,
    output logic [7:0] sec_BCD,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       ctrl_err,
    output logic       stable,
    output logic       scan_lost
);

    localparam int              TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);
    localparam logic [3:0]      ST_MAX = 4'(STABLE_FRAMES);

    // Input stage
    logic [7:0]      display_r;
    logic [3:0]      ctrl_r;
    logic            unused_dp_s;

    // Decode / capture
    logic [3:0]      dec_nibble_s;
    logic            dec_bad_s;
    logic [2:0]      zeros_s;
    logic            capture_s;
    logic            multi_zero_s;
    logic [3:0]      sel_s;
    logic            frame_done_s;

    // Shadow frame
    digit_t          slot_r [4];
    digit_t          frame_s [4];
    logic [3:0]      seen_r;
    logic [3:0]      seen_next_s;
    logic            any_bad_s;
    logic [7:0]      frame_min_s;
    logic [7:0]      frame_sec_s;
    logic            same_s;

    // Outputs and counters
    logic [7:0]      min_bcd_r;
    logic [7:0]      sec_bcd_r;
    logic            frame_valid_r;
    logic            frame_err_r;
    logic            ctrl_err_r;
    logic            stable_r;
    logic            scan_lost_r;
    logic [3:0]      stab_cnt_r;
    logic [3:0]      stab_next_s;
    logic [TO_W-1:0] to_cnt_r;
    logic [TO_W-1:0] to_next_s;
    logic            scan_lost_next_s;

    // The decimal point carries no information for the decoder.
    assign unused_dp_s = display_r[0];

    ssd_pattern_decoder u_dec (
        .seg    (display_r[7:1]),
        .nibble (dec_nibble_s),
        .bad    (dec_bad_s)
    );

    // Register the raw pins so all decode logic works on a clean sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_r <= 8'hFF;
            ctrl_r    <= 4'hF;
        end else begin
            display_r <= display;
            ctrl_r    <= ctrl;
        end
    end

    // Classify the sampled ctrl: single digit capture, blank, or multi-enable.
    always_comb begin
        zeros_s      = zero_count(ctrl_r);
        capture_s    = (zeros_s == 3'd1);
        multi_zero_s = (zeros_s > 3'd1);
        if (capture_s) begin
            sel_s = ~ctrl_r;
        end else begin
            sel_s = 4'h0;
        end
        frame_done_s = capture_s && ((seen_r | sel_s) == 4'hF);
    end

    // Assemble the candidate frame, bypassing the digit being captured now.
    always_comb begin
        any_bad_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (sel_s[i]) begin
                frame_s[i] = {dec_nibble_s, dec_bad_s};
            end else begin
                frame_s[i] = slot_r[i];
            end
            any_bad_s = any_bad_s | frame_s[i].bad;
        end
        frame_min_s = {frame_s[DIG_MIN_T].nibble, frame_s[DIG_MIN_O].nibble};
        frame_sec_s = {frame_s[DIG_SEC_T].nibble, frame_s[DIG_SEC_O].nibble};
        same_s      = (frame_min_s == min_bcd_r) && (frame_sec_s == sec_bcd_r);
    end

    // Track which slots have been filled since the last frame boundary.
    always_comb begin
        seen_next_s = seen_r;
        if (multi_zero_s) begin
            seen_next_s = 4'h0;
        end else if (frame_done_s) begin
            seen_next_s = 4'h0;
        end else if (capture_s) begin
            seen_next_s = seen_r | sel_s;
        end else begin
            seen_next_s = seen_r;
        end
    end

    // Next value of the no-capture timeout and the scan-lost flag it implies.
    always_comb begin
        to_next_s = to_cnt_r;
        if (capture_s) begin
            to_next_s = '0;
        end else if (to_cnt_r == TO_MAX) begin
            to_next_s = to_cnt_r;
        end else begin
            to_next_s = to_cnt_r + TO_W'(1);
        end
        scan_lost_next_s = (to_next_s == TO_MAX);
    end

    // Next stability count: pinned to zero while the scan is lost.
    always_comb begin
        stab_next_s = stab_cnt_r;
        if (scan_lost_next_s) begin
            stab_next_s = 4'd0;
        end else if (frame_done_s) begin
            if (any_bad_s) begin
                stab_next_s = 4'd0;
            end else if (!same_s) begin
                stab_next_s = 4'd1;
            end else if (stab_cnt_r >= ST_MAX) begin
                stab_next_s = ST_MAX;
            end else begin
                stab_next_s = stab_cnt_r + 4'd1;
            end
        end else begin
            stab_next_s = stab_cnt_r;
        end
    end

    // Shadow slots and the seen mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                slot_r[i] <= '0;
            end
            seen_r <= 4'h0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sel_s[i]) begin
                    slot_r[i] <= {dec_nibble_s, dec_bad_s};
                end else begin
                    slot_r[i] <= slot_r[i];
                end
            end
            seen_r <= seen_next_s;
        end
    end

    // Published time value and the per-frame / ctrl error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_bcd_r     <= 8'h00;
            sec_bcd_r     <= 8'h00;
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            ctrl_err_r    <= 1'b0;
        end else begin
            frame_valid_r <= frame_done_s;
            frame_err_r   <= frame_done_s && any_bad_s;
            ctrl_err_r    <= multi_zero_s;
            if (frame_done_s && !any_bad_s) begin
                min_bcd_r <= frame_min_s;
                sec_bcd_r <= frame_sec_s;
            end else begin
                min_bcd_r <= min_bcd_r;
                sec_bcd_r <= sec_bcd_r;
            end
        end
    end

    // Stability and timeout counters with their status flags on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt_r  <= 4'd0;
            stable_r    <= 1'b0;
            to_cnt_r    <= '0;
            scan_lost_r <= 1'b0;
        end else begin
            stab_cnt_r  <= stab_next_s;
            stable_r    <= (stab_next_s == ST_MAX);
            to_cnt_r    <= to_next_s;
            scan_lost_r <= scan_lost_next_s;
        end
    end

    assign min_BCD     = min_bcd_r;
    assign sec_BCD     = sec_bcd_r;
    assign frame_valid = frame_valid_r;
    assign frame_err   = frame_err_r;
    assign ctrl_err    = ctrl_err_r;
    assign stable      = stable_r;
    assign scan_lost   = scan_lost_r;

endmodule
